// File: rtl/cnn_pkg.sv
// Shared CNN constants: default image geometry, pixel width, convolution window size
// and the state encoding of the window controller.
package cnn_pkg;

   localparam int IMG_W_DEF = 28;
   localparam int IMG_H_DEF = 28;
   localparam int PIX_W_DEF = 8;
   localparam int WIN_SIZE  = 3;
   localparam int WIN_ELEMS = WIN_SIZE * WIN_SIZE;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      PRESENT,
      FIN
   } win_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Maps (output row, output col, element index k) to a pixel address plus a bounds flag.
// With CONV_ZERO_PAD_EN the window is centred on the output coordinate, otherwise anchored top-left.
module window_addr_gen
   import cnn_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int IMG_H  = IMG_H_DEF,
   parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
   input  logic [15:0]       out_row,
   input  logic [15:0]       out_col,
   input  logic [3:0]        k,
   output logic [ADDR_W-1:0] addr,
   output logic              in_bounds
);

`ifdef CONV_ZERO_PAD_EN
   localparam int ORIGIN = 1;
`else
   localparam int ORIGIN = 0;
`endif

   int pix_row;
   int pix_col;

   // Signed arithmetic so that the padded border goes negative instead of wrapping.
   always_comb begin
      pix_row   = int'(out_row) + int'(k) / WIN_SIZE - ORIGIN;
      pix_col   = int'(out_col) + int'(k) % WIN_SIZE - ORIGIN;
      in_bounds = (pix_row >= 0) && (pix_row < IMG_H) && (pix_col >= 0) && (pix_col < IMG_W);
      addr      = '0;
      if (in_bounds) begin
         addr = ADDR_W'(pix_row * IMG_W + pix_col);
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Scans an image held in a one-cycle-latency memory and presents 3x3 windows in raster order
// over a valid/ready handshake. Define CONV_ZERO_PAD_EN for same-size output with zero padding.
module conv_window_ctrl
   import cnn_pkg::*;
#(
   parameter int IMG_W    = IMG_W_DEF,
   parameter int IMG_H    = IMG_H_DEF,
   parameter int PIX_W    = PIX_W_DEF,
   localparam int ADDR_W  = $clog2(IMG_W * IMG_H)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic                          mem_rd_en,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic [PIX_W-1:0]              mem_rd_data,
   output logic                          win_valid,
   input  logic                          win_ready,
   output logic [WIN_ELEMS*PIX_W-1:0]    win_data,
   output logic [15:0]                   out_row,
   output logic [15:0]                   out_col
);

`ifdef CONV_ZERO_PAD_EN
   localparam int OUT_W = IMG_W;
   localparam int OUT_H = IMG_H;
`else
   localparam int OUT_W = IMG_W - 2;
   localparam int OUT_H = IMG_H - 2;
`endif

   // Slot WIN_ELEMS issues nothing; it only captures the data of the last element.
   localparam logic [3:0] LAST_SLOT = 4'(WIN_ELEMS);

   win_state_t                    state_q, state_d;
   logic [3:0]                    slot_q, slot_d;
   logic                          rd_prev_q, rd_prev_d;
   logic [WIN_ELEMS*PIX_W-1:0]    win_q, win_d;
   logic [15:0]                   row_q, row_d;
   logic [15:0]                   col_q, col_d;
   logic [ADDR_W-1:0]             elem_addr;
   logic                          elem_in_bounds;
   logic                          last_win;

   window_addr_gen #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .out_row   (row_q),
      .out_col   (col_q),
      .k         (slot_q),
      .addr      (elem_addr),
      .in_bounds (elem_in_bounds)
   );

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == FIN);
      win_valid = (state_q == PRESENT);
      mem_rd_en = (state_q == FETCH) && (slot_q < LAST_SLOT) && elem_in_bounds;
      mem_addr  = mem_rd_en ? elem_addr : '0;
      win_data  = win_q;
      out_row   = row_q;
      out_col   = col_q;
      last_win  = (row_q == 16'(OUT_H - 1)) && (col_q == 16'(OUT_W - 1));
   end

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      rd_prev_d = mem_rd_en;
      win_d     = win_q;
      row_d     = row_q;
      col_d     = col_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FETCH;
               slot_d  = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         FETCH: begin
            // Data read in slot e arrives in slot e+1; skipped (padded) reads capture zero.
            for (int e = 0; e < WIN_ELEMS; e++) begin
               if (slot_q == 4'(e + 1)) begin
                  win_d[e*PIX_W +: PIX_W] = rd_prev_q ? mem_rd_data : '0;
               end
            end
            if (slot_q == LAST_SLOT) begin
               state_d = PRESENT;
               slot_d  = '0;
            end else begin
               slot_d = slot_q + 4'd1;
            end
         end
         PRESENT: begin
            if (win_ready) begin
               if (last_win) begin
                  state_d = FIN;
               end else begin
                  state_d = FETCH;
                  slot_d  = '0;
                  if (col_q == 16'(OUT_W - 1)) begin
                     col_d = '0;
                     row_d = row_q + 16'd1;
                  end else begin
                     col_d = col_q + 16'd1;
                  end
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         slot_q    <= '0;
         rd_prev_q <= 1'b0;
         win_q     <= '0;
         row_q     <= '0;
         col_q     <= '0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         rd_prev_q <= rd_prev_d;
         win_q     <= win_d;
         row_q     <= row_d;
         col_q     <= col_d;
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on a 4x4 image whose memory word at address a equals a.
// Covers both builds: default (valid convolution) and CONV_ZERO_PAD_EN (zero padding).
module tb_conv_window_ctrl;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 4;

   logic                clk;
   logic                rst;
   logic                start;
   logic                busy;
   logic                done;
   logic                mem_rd_en;
   logic [ADDR_W-1:0]   mem_addr;
   logic [PIX_W-1:0]    mem_rd_data;
   logic                win_valid;
   logic                win_ready;
   logic [9*PIX_W-1:0]  win_data;
   logic [15:0]         out_row;
   logic [15:0]         out_col;

   int vectors   = 0;
   int errors    = 0;
   int cyc       = 0;
   int glitch_at = -1;
   int done_cnt  = 0;
   int hs_cnt    = 0;

   logic [71:0] exp_win [4];
   int exp_addr   [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
   int first_addr [4] = '{0, 1, 4, 5};
   int pad_en     [9] = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
   int pad_addr   [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};

   conv_window_ctrl #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .PIX_W (PIX_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_data    (win_data),
      .out_row     (out_row),
      .out_col     (out_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Image memory: word a holds a; garbage is returned when no read was issued.
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? PIX_W'(mem_addr) : 8'hEE;
   end

   always @(posedge clk) begin
      if (!rst && done === 1'b1) done_cnt <= done_cnt + 1;
      if (!rst && win_valid === 1'b1 && win_ready === 1'b1) hs_cnt <= hs_cnt + 1;
   end

   function automatic logic [71:0] packWin(input int e0, input int e1, input int e2,
                                            input int e3, input int e4, input int e5,
                                            input int e6, input int e7, input int e8);
      return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = (cyc == glitch_at);
   endtask

   task automatic applyStimulus(input logic s, input logic r, input logic rdy);
      start     = s;
      rst       = r;
      win_ready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_busy"},      busy,      0);
      checkOutput({tag, "_done"},      done,      0);
      checkOutput({tag, "_rd_en"},     mem_rd_en, 0);
      checkOutput({tag, "_addr"},      mem_addr,  0);
      checkOutput({tag, "_valid"},     win_valid, 0);
      checkOutput({tag, "_win_data"},  win_data,  0);
      checkOutput({tag, "_out_row"},   out_row,   0);
      checkOutput({tag, "_out_col"},   out_col,   0);
   endtask

   task automatic waitValid;
      int n = 0;
      while (win_valid !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checkOutput("valid_wait", win_valid, 1);
   endtask

   // Consume no-pad window w (of 4), optionally stalling it, then check what follows the handshake.
   task automatic consumeWindow(input int w, input bit stall, input bit timed);
      win_ready = !stall;
      waitValid();
      if (timed) checkOutput($sformatf("valid_cycle_w%0d", w), cyc, 11 * (w + 1));
      checkOutput($sformatf("win_data_w%0d", w), win_data, exp_win[w]);
      checkOutput($sformatf("out_row_w%0d", w), out_row, w / 2);
      checkOutput($sformatf("out_col_w%0d", w), out_col, w % 2);
      if (stall) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall%0d_valid", i), win_valid, 1);
            checkOutput($sformatf("stall%0d_data", i),  win_data,  exp_win[w]);
            checkOutput($sformatf("stall%0d_col", i),   out_col,   w % 2);
            checkOutput($sformatf("stall%0d_rd_en", i), mem_rd_en, 0);
            tick();
         end
         win_ready = 1'b1;
      end
      tick();
      if (w < 3) begin
         checkOutput($sformatf("next_fetch_rd_en_w%0d", w), mem_rd_en, 1);
         checkOutput($sformatf("next_fetch_addr_w%0d", w),  mem_addr,  first_addr[w + 1]);
      end else begin
         checkOutput("fin_done", done, 1);
         checkOutput("fin_busy", busy, 1);
         tick();
         checkOutput("after_fin_done", done, 0);
         checkOutput("after_fin_busy", busy, 0);
      end
   endtask

   // Full no-pad scan with cycle-exact read checks on the first window.
   task automatic runScan(input int glitch);
      cyc       = 0;
      glitch_at = glitch;
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("busy_c1", busy, 1);
      for (int k = 0; k < 9; k++) begin
         checkOutput($sformatf("rd_en_c%0d", k + 1), mem_rd_en, 1);
         checkOutput($sformatf("addr_c%0d", k + 1),  mem_addr,  exp_addr[k]);
         tick();
      end
      checkOutput("rd_en_c10", mem_rd_en, 0);
      checkOutput("addr_c10",  mem_addr,  0);
      checkOutput("valid_c10", win_valid, 0);
      for (int w = 0; w < 4; w++) consumeWindow(w, 1'b0, 1'b1);
      glitch_at = -1;
   endtask

   initial begin
      exp_win[0] = packWin(0, 1, 2, 4, 5, 6, 8, 9, 10);
      exp_win[1] = packWin(1, 2, 3, 5, 6, 7, 9, 10, 11);
      exp_win[2] = packWin(4, 5, 6, 8, 9, 10, 12, 13, 14);
      exp_win[3] = packWin(5, 6, 7, 9, 10, 11, 13, 14, 15);

      applyStimulus(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      tick();
      tick();
      checkIdleOutputs("reset");
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();

`ifndef CONV_ZERO_PAD_EN
      $display("[TB] scan 1: timing, order, and a start pulse at cycle 20 while busy");
      runScan(20);
      repeat (15) tick();
      checkOutput("scan1_done_count", done_cnt, 1);
      checkOutput("scan1_windows",    hs_cnt,   4);
      checkOutput("scan1_idle_busy",  busy,     0);

      $display("[TB] scan 2: backpressure on window (0,1)");
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
      consumeWindow(0, 1'b0, 1'b1);
      consumeWindow(1, 1'b1, 1'b0);
      consumeWindow(2, 1'b0, 1'b0);
      consumeWindow(3, 1'b0, 1'b0);
      checkOutput("scan2_done_count", done_cnt, 2);
      checkOutput("scan2_windows",    hs_cnt,   8);

      $display("[TB] scan 3: reset during slot 4 of window (0,1), then a fresh scan");
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
      consumeWindow(0, 1'b0, 1'b1);
      repeat (4) tick();
      checkOutput("abort_slot4_rd_en", mem_rd_en, 1);
      checkOutput("abort_slot4_addr",  mem_addr,  6);
      applyStimulus(1'b0, 1'b1, 1'b1);
      tick();
      checkIdleOutputs("abort");
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (20) tick();
      checkOutput("abort_no_done",   done_cnt, 2);
      checkOutput("abort_stays_idle", busy,    0);
      runScan(-1);
      checkOutput("rescan_done_count", done_cnt, 3);
      checkOutput("rescan_windows",    hs_cnt,   13);
`else
      $display("[TB] zero-padded scan of 16 windows");
      cyc = 0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
      for (int k = 0; k < 9; k++) begin
         checkOutput($sformatf("pad_rd_en_c%0d", k + 1), mem_rd_en, pad_en[k]);
         checkOutput($sformatf("pad_addr_c%0d", k + 1),  mem_addr,  pad_addr[k]);
         tick();
      end
      for (int w = 0; w < 16; w++) begin
         waitValid();
         if (w == 0) begin
            checkOutput("pad_valid_cycle", cyc, 11);
            checkOutput("pad_win_0_0", win_data, packWin(0, 0, 0, 0, 0, 1, 0, 4, 5));
         end
         if (w == 15) begin
            checkOutput("pad_win_3_3", win_data, packWin(10, 11, 0, 14, 15, 0, 0, 0, 0));
         end
         checkOutput($sformatf("pad_row_w%0d", w), out_row, w / 4);
         checkOutput($sformatf("pad_col_w%0d", w), out_col, w % 4);
         tick();
      end
      checkOutput("pad_fin_done", done, 1);
      tick();
      checkOutput("pad_idle_busy",   busy,     0);
      checkOutput("pad_done_count",  done_cnt, 1);
      checkOutput("pad_windows",     hs_cnt,   16);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameters SHALL be: IMG_W, 28, image width in pixels; IMG_H, 28, image height in pixels; PIX_W, 8, pixel width in bits.
REQ-002 ADDR_W SHALL be a derived localparam equal to clog2(IMG_W*IMG_H).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin scanning one image; sampled only in IDLE.
REQ-007 busy  output  1  scan in progress.
REQ-008 done  output  1  one-cycle pulse after the last window handshake.
REQ-009 mem_rd_en  output  1  image memory read strobe.
REQ-010 mem_addr  output  ADDR_W  pixel address, row*IMG_W+col.
REQ-011 mem_rd_data  input  PIX_W  read data, valid exactly one cycle after mem_rd_en.
REQ-012 win_valid  output  1  3x3 window available.
REQ-013 win_ready  input  1  consumer accepts the window.
REQ-014 win_data  output  9*PIX_W  element k=3*dr+dc at bits [k*PIX_W +: PIX_W].
REQ-015 out_row, out_col  output  16 each  output coordinate of the current window.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, PRESENT and FIN.
- IDLE->FETCH on start.
- FETCH->PRESENT after 9 element slots plus 1 capture cycle.
- PRESENT->FETCH on a handshake that is not the last.
- PRESENT->FIN on the last handshake.
- FIN->IDLE after one cycle, with done=1 in FIN.
REQ-017 FETCH SHALL issue element k in slot k (k=0..8, one per cycle, row-major within the window) and capture its data one cycle later, so 10 cycles elapse per window.
REQ-018 The first win_valid SHALL assert 11 cycles after the cycle in which start is sampled.
REQ-019 The handshake SHALL complete when win_valid and win_ready are both 1 on the same edge; win_data, out_row and out_col SHALL stay stable while win_valid=1 and win_ready=0.
REQ-020 Windows SHALL be emitted in raster order (out_col fastest); out_col SHALL wrap to 0 and out_row SHALL increment at the row end.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 busy SHALL be 1 from the cycle after start is sampled through FIN inclusive.
REQ-023 mem_addr SHALL be 0 whenever mem_rd_en=0.

Reset
REQ-024 On rst the block SHALL enter IDLE, and busy, done, mem_rd_en, mem_addr, win_valid, win_data, out_row and out_col SHALL all be 0 on the next edge.
REQ-025 rst SHALL abort a scan in progress at any state, including mid-FETCH and PRESENT with win_ready=0, and no done pulse SHALL be produced.

Configuration
REQ-026 With macro CONV_ZERO_PAD_EN defined:
- output size SHALL be IMG_H x IMG_W, and window (r,c) SHALL be centred on pixel (r,c).
- out-of-bounds elements SHALL still occupy their slot with mem_rd_en=0 and SHALL be captured as 0.
REQ-027 Without CONV_ZERO_PAD_EN:
- output size SHALL be (IMG_H-2) x (IMG_W-2), and window (r,c) SHALL have its top-left at pixel (r,c).
- every slot SHALL issue a read.

Structure
REQ-028 IMG_W/IMG_H defaults, PIX_W and the window size constant 3 SHALL live in the shared package cnn_pkg.
REQ-029 The per-element coordinate, bounds check and address computation SHALL be a sub-module window_addr_gen.
- window_addr_gen is combinational.
- Inputs: out_row, out_col, k.
- Outputs: addr, in_bounds.

Verification (IMG_W=4, IMG_H=4, memory word at address a equals a)
REQ-030 No pad: pulse start -> 4 windows in order (0,0),(0,1),(1,0),(1,1); window (0,0)={0,1,2,4,5,6,8,9,10}; done one cycle after the 4th handshake.
REQ-031 CONV_ZERO_PAD_EN: pulse start -> 16 windows; window (0,0)={0,0,0,0,0,1,0,4,5}; only 4 reads issued for that window; window (3,3)={10,11,0,14,15,0,0,0,0}.
REQ-032 Backpressure: hold win_ready=0 for 5 cycles on window (0,1) -> win_valid, win_data and out_col stable throughout; no mem_rd_en during the stall; window (1,0) fetch starts the cycle after the handshake.
REQ-033 Pulse start again at cycle 20 while busy -> ignored; exactly 4 windows and one done pulse.
REQ-034 Assert rst during slot 4 of window (0,1) -> all outputs 0 the next cycle; no done; a fresh start then reproduces REQ-030 exactly.
REQ-035 Timing check: start sampled at cycle 0 -> mem_rd_en=1 at cycles 1..9 with addresses 0,1,2,4,5,6,8,9,10; win_valid=1 at cycle 11.
